patch_scan_ctrl: RTL and testbench

Scheduler that walks a convolution patch window across an input image and sequences the processor-enable generator and processing-element array. It sits between the image row buffer, which presents patch data with a valid/ready handshake, and the processor-enable generator, which it drives with `cycle_detect` steps and a per-row clear. It latches and validates the patch geometry, computes the patch-grid dimensions, issues one step per accepted patch column, and signals completion.

---
 rtl/patch_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_patch_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/patch_scan_ctrl.sv
// Patch-window scheduler: validates patch geometry, sizes the patch grid, then
// steps the processor-enable generator once per accepted patch column.
module patch_scan_ctrl #(
  parameter int IMG_W_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            patch_size,
  input  logic [2:0]            stride,
  input  logic [IMG_W_BITS-1:0] img_w,
  input  logic [IMG_W_BITS-1:0] img_h,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cycle_detect,
  output logic                  pe_clr,
  output logic [IMG_W_BITS-1:0] patch_x,
  output logic [IMG_W_BITS-1:0] patch_y,
  output logic [IMG_W_BITS-1:0] n_x,
  output logic [IMG_W_BITS-1:0] n_y,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  localparam int W = IMG_W_BITS;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [2:0] {IDLE, CHECK, CALC, ROW_INIT, STEP, ROW_END, DONE} state_t;

  state_t       state, state_n;
  logic [2:0]   p_q, s_q;
  logic [W-1:0] w_q, h_q, rem_x, rem_y;
  logic [W-1:0] p_ext, s_ext;
  logic         legal, last_col, last_row, hs_p0, step_p1;

  function automatic logic cfg_legal(input logic [2:0] p, input logic [2:0] s,
                                     input logic [W-1:0] w, input logic [W-1:0] h);
    logic [W-1:0] pw;
    pw = {{(W-3){1'b0}}, p};
    return ((p == 3'd3) || (p == 3'd5) || (p == 3'd7)) && (s != 3'd0) && (s <= p) &&
           (pw <= w) && (pw <= h);
  endfunction

  assign p_ext    = {{(W-3){1'b0}}, p_q};
  assign s_ext    = {{(W-3){1'b0}}, s_q};
  assign legal    = cfg_legal(p_q, s_q, w_q, h_q);
  assign last_col = (patch_x == (n_x - ONE));
  assign last_row = (patch_y == (n_y - ONE));
  assign hs_p0    = (state == STEP) && in_valid;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start) state_n = CHECK;
      CHECK:    state_n = legal ? CALC : IDLE;
      CALC:     if ((rem_x < s_ext) && (rem_y < s_ext)) state_n = ROW_INIT;
      ROW_INIT: state_n = STEP;
      STEP:     if (in_valid && last_col) state_n = ROW_END;
      ROW_END:  state_n = last_row ? DONE : ROW_INIT;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  assign in_ready     = (state == STEP);
  assign pe_clr       = (state == ROW_INIT);
  assign done         = (state == DONE);
  assign cfg_err      = (state == CHECK) && !legal;
  assign busy         = (state != IDLE);
  assign cycle_detect = step_p1;

  // p0 -> p1: handshake becomes the registered step pulse; abort does not cancel it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      step_p1 <= 1'b0;
      p_q     <= '0;
      s_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      rem_x   <= '0;
      rem_y   <= '0;
      n_x     <= '0;
      n_y     <= '0;
      patch_x <= '0;
      patch_y <= '0;
    end else begin
      state   <= state_n;
      step_p1 <= hs_p0;
      if (!abort) begin
        unique case (state)
          IDLE: if (start) begin
            p_q <= patch_size;
            s_q <= stride;
            w_q <= img_w;
            h_q <= img_h;
          end
          CHECK: if (legal) begin
            rem_x   <= w_q - p_ext;
            rem_y   <= h_q - p_ext;
            n_x     <= ONE;
            n_y     <= ONE;
            patch_x <= '0;
            patch_y <= '0;
          end
          // Division by repeated subtraction, both axes in parallel
          CALC: begin
            if (rem_x >= s_ext) begin
              rem_x <= rem_x - s_ext;
              n_x   <= n_x + ONE;
            end
            if (rem_y >= s_ext) begin
              rem_y <= rem_y - s_ext;
              n_y   <= n_y + ONE;
            end
          end
          ROW_INIT: patch_x <= '0;
          STEP:     if (in_valid && !last_col) patch_x <= patch_x + ONE;
          ROW_END:  if (!last_row) patch_y <= patch_y + ONE;
          default:  ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_patch_scan_ctrl.sv
// Bench for patch_scan_ctrl: event-level scan model checked every cycle, plus
// directed scenarios with hand-computed step counts and latencies.
module tb_patch_scan_ctrl;
  localparam int WB = 6;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid;
  logic [2:0]    patch_size, stride;
  logic [WB-1:0] img_w, img_h;
  logic          in_ready, cycle_detect, pe_clr, busy, done, cfg_err;
  logic [WB-1:0] patch_x, patch_y, n_x, n_y;

  patch_scan_ctrl #(.IMG_W_BITS(WB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .patch_size(patch_size), .stride(stride), .img_w(img_w), .img_h(img_h),
    .in_valid(in_valid), .in_ready(in_ready), .cycle_detect(cycle_detect),
    .pe_clr(pe_clr), .patch_x(patch_x), .patch_y(patch_y), .n_x(n_x), .n_y(n_y),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan model: expectations derived from grid size and handshake order
  int cyc = 0;
  bit armed = 0, active = 0, ready_exp = 0, zero_valid = 0, hold_valid = 0, prev_hs = 0;
  int pend_pe = -1, pend_done = -1, pend_cfg = -1;
  int m_nx = 0, m_ny = 0, idx = 0, total = 0;
  int cd_seen = 0, pe_seen = 0, done_seen = 0, cfg_seen = 0;
  int start_cyc = -1, first_pe_cyc = -1, last_hs_cyc = -1, done_cyc = -1, cfg_cyc = -1;

  always @(negedge clk) begin : monitor
    bit hs, was_active;
    int p, s, w, h, qx, qy;
    cyc++;
    hs = in_ready && in_valid;
    was_active = active;
    if (armed) begin
      chk("cycle_detect", int'(cycle_detect), int'(prev_hs));
      chk("in_ready", int'(in_ready), int'(ready_exp));
      chk("pe_clr", int'(pe_clr), int'(cyc == pend_pe));
      chk("done", int'(done), int'(cyc == pend_done));
      chk("cfg_err", int'(cfg_err), int'(cyc == pend_cfg));
      chk("busy", int'(busy), int'(active));
      if (zero_valid) chk("idle_zero", int'({patch_x, patch_y, n_x, n_y}), 0);
      if (hold_valid) begin
        chk("hold_patch_x", int'(patch_x), m_nx - 1);
        chk("hold_patch_y", int'(patch_y), m_ny - 1);
        chk("hold_n_x", int'(n_x), m_nx);
        chk("hold_n_y", int'(n_y), m_ny);
      end
      if (cyc == pend_pe) begin
        chk("grid_n_x", int'(n_x), m_nx);
        chk("grid_n_y", int'(n_y), m_ny);
        if (first_pe_cyc < 0) first_pe_cyc = cyc;
      end
      if (hs && active) begin
        chk("hs_patch_x", int'(patch_x), idx % m_nx);
        chk("hs_patch_y", int'(patch_y), idx / m_nx);
        last_hs_cyc = cyc;
      end
      if (cycle_detect) cd_seen++;
      if (pe_clr) pe_seen++;
      if (done) begin done_seen++; done_cyc = cyc; end
      if (cfg_err) begin cfg_seen++; cfg_cyc = cyc; end
    end
    prev_hs = hs && rst;
    if (!rst) begin
      armed = 1; active = 0; ready_exp = 0; zero_valid = 1; hold_valid = 0;
      pend_pe = -1; pend_done = -1; pend_cfg = -1;
    end else if (armed && abort) begin
      active = 0; ready_exp = 0; zero_valid = 0; hold_valid = 0;
      pend_pe = -1; pend_done = -1; pend_cfg = -1;
    end else if (armed) begin
      if (cyc == pend_pe) ready_exp = 1;
      if (hs && active) begin
        if (idx % m_nx == m_nx - 1) begin
          ready_exp = 0;
          if (idx == total - 1) pend_done = cyc + 2;
          else pend_pe = cyc + 2;
        end
        idx++;
      end
      if (cyc == pend_done) begin active = 0; hold_valid = 1; end
      if (cyc == pend_cfg) active = 0;
      if (!was_active && start) begin
        p = int'(patch_size); s = int'(stride); w = int'(img_w); h = int'(img_h);
        active = 1; zero_valid = 0; hold_valid = 0; start_cyc = cyc;
        if ((p == 3 || p == 5 || p == 7) && s >= 1 && s <= p && p <= w && p <= h) begin
          qx = (w - p) / s; qy = (h - p) / s;
          m_nx = qx + 1; m_ny = qy + 1; total = m_nx * m_ny; idx = 0;
          pend_pe = cyc + 3 + ((qx > qy) ? qx : qy);
          first_pe_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        end else begin
          pend_cfg = cyc + 1; cfg_cyc = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input int p, input int s, input int w, input int h);
    patch_size = 3'(p); stride = 3'(s); img_w = WB'(w); img_h = WB'(h);
  endtask

  // Pulses start, then feeds in_valid until done or the cycle budget expires
  task automatic run_scan(input int p, input int s, input int w, input int h,
                          input bit gaps, input bit nudge);
    int d0;
    bit seen;
    set_cfg(p, s, w, h);
    d0 = done_seen; seen = 0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = nudge && (k == 60 || k == 61 || k == 200);
      tick();
      if (done_seen != d0) seen = 1;
    end
    in_valid = 0; start = 0;
    if (!seen) chk("scan_timeout", 0, 1);
    tick();
  endtask

  task automatic run_illegal(input string name, input int p, input int s, input int w, input int h);
    int c0, d0;
    set_cfg(p, s, w, h);
    c0 = cfg_seen; d0 = done_seen;
    start = 1; tick(); start = 0;
    repeat (4) tick();
    chk({name, "_cfg_err"}, cfg_seen - c0, 1);
    chk({name, "_cfg_lat"}, cfg_cyc - start_cyc, 1);
    chk({name, "_no_done"}, done_seen - d0, 0);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_step(input int target);
    bit hit;
    hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      in_valid = 1;
      if (idx == target && in_ready) hit = 1;
      else tick();
    end
    if (!hit) chk("step_wait_timeout", 0, 1);
  endtask

  initial begin : stim
    int cd0, pe0, d0;
    rst = 0; start = 0; abort = 0; in_valid = 0;
    set_cfg(3, 1, 28, 28);
    repeat (3) tick();
    rst = 1;
    tick();
    chk("reset_outputs", int'({busy, in_ready, cycle_detect, pe_clr, done, cfg_err}), 0);
    chk("reset_grid", int'({patch_x, patch_y, n_x, n_y}), 0);

    cd0 = cd_seen; pe0 = pe_seen; d0 = done_seen;
    run_scan(3, 1, 28, 28, 0, 0);
    chk("A_steps", cd_seen - cd0, 676);
    chk("A_pe_clr", pe_seen - pe0, 26);
    chk("A_done", done_seen - d0, 1);
    chk("A_calc_cycles", first_pe_cyc - start_cyc - 2, 26);
    chk("A_n_x", int'(n_x), 26);
    chk("A_n_y", int'(n_y), 26);

    cd0 = cd_seen; pe0 = pe_seen;
    run_scan(5, 2, 28, 28, 1, 1);
    chk("B_steps", cd_seen - cd0, 144);
    chk("B_pe_clr", pe_seen - pe0, 12);
    chk("B_n_x", int'(n_x), 12);
    chk("B_final_x", int'(patch_x), 11);

    cd0 = cd_seen;
    run_scan(7, 7, 28, 14, 1, 0);
    chk("C_steps", cd_seen - cd0, 8);
    chk("C_n_x", int'(n_x), 4);
    chk("C_n_y", int'(n_y), 2);
    chk("C_done_lat", done_cyc - last_hs_cyc, 2);

    run_illegal("P4", 4, 1, 28, 28);
    run_illegal("S0", 3, 0, 28, 28);
    run_illegal("S4", 3, 4, 28, 28);
    run_illegal("W5", 7, 3, 5, 28);

    // Abort on the cycle of the 50th handshake
    set_cfg(3, 1, 28, 28);
    cd0 = cd_seen; d0 = done_seen;
    start = 1; tick(); start = 0;
    wait_step(49);
    abort = 1; tick(); abort = 0; in_valid = 0;
    repeat (10) tick();
    chk("abort_steps", cd_seen - cd0, 50);
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_busy", int'(busy), 0);

    cd0 = cd_seen; d0 = done_seen;
    run_scan(3, 1, 28, 28, 0, 0);
    chk("A2_steps", cd_seen - cd0, 676);
    chk("A2_done", done_seen - d0, 1);

    // Reset pulse mid-STEP
    set_cfg(7, 7, 28, 14);
    d0 = done_seen;
    start = 1; tick(); start = 0;
    wait_step(3);
    rst = 0; tick(); rst = 1;
    chk("rst_outputs", int'({busy, in_ready, cycle_detect, pe_clr, done, cfg_err}), 0);
    chk("rst_grid", int'({patch_x, patch_y, n_x, n_y}), 0);
    repeat (20) tick();
    in_valid = 0;
    chk("rst_no_done", done_seen - d0, 0);
    chk("rst_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
